serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor that processes one operand bit per clock through a single full-adder cell, with a start/busy/done handshake. It is the sequential successor to the combinational half/full-adder cells: it trades latency for area, and generalises to any operand width plus a subtract mode with carry and signed-overflow flags. It sits as a small arithmetic slave under a controller that issues one operation at a time.

---
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor built around one full-adder cell.
// One operand bit per clock, LSB first, with a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_s;
  logic c_out;

  assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_out = (a_sh_q[0] & b_sh_q[0]) |
                 (a_sh_q[0] & c_q) |
                 (b_sh_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract as a + ~b + 1: the +1 enters as the initial carry.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_q >> 1;
        res_d[WIDTH-1] = bit_s;
        c_d    = c_out;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB.
          sum_d   = res_d;
          carry_d = c_out;
          ovf_d   = c_q ^ c_out;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=1.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st8, sb8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, c8, v8;

  logic st1, sb1;
  logic [0:0] a1, b1, sum1;
  logic busy1, done1, c1, v1;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .sum(sum8), .carry(c8), .overflow(v8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .sum(sum1), .carry(c1), .overflow(v1)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    int         gap;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT pulses done.
  int cyc = 0, last8 = 0, last1 = 0, bc8 = 0, bc1 = 0;
  logic rstp = 1'b1;
  logic [9:0] p8 = '0;
  logic [2:0] p1 = '0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst) begin
      bc8 = 0;
      bc1 = 0;
    end else begin
      if (busy8) bc8++;
      if (busy1) bc1++;
      if (done8) begin
        if (q8.size() == 0) chk("spurious_done8", 32'(done8), 0);
        else begin
          e = q8.pop_front();
          chk("sum8", 32'(sum8), 32'(e.s));
          chk("carry8", 32'(c8), 32'(e.c));
          chk("ovf8", 32'(v8), 32'(e.v));
          chk("busy_cycles8", bc8, 8);
          chk("busy_in_done8", 32'(busy8), 0);
          if (e.gap != 0) chk("done_gap8", cyc - last8, e.gap);
        end
        last8 = cyc;
        bc8 = 0;
      end
      if (done1) begin
        if (q1.size() == 0) chk("spurious_done1", 32'(done1), 0);
        else begin
          e = q1.pop_front();
          chk("sum1", 32'(sum1), 32'(e.s));
          chk("carry1", 32'(c1), 32'(e.c));
          chk("ovf1", 32'(v1), 32'(e.v));
          chk("busy_cycles1", bc1, 1);
        end
        last1 = cyc;
        bc1 = 0;
      end
      if (!rstp && !done8) chk("hold8", 32'({sum8, c8, v8}), 32'(p8));
      if (!rstp && !done1) chk("hold1", 32'({sum1, c1, v1}), 32'(p1));
    end
    rstp = rst;
    p8 = {sum8, c8, v8};
    p1 = {sum1, c1, v1};
  end

  // Counts negedges after a start edge until done (bounded).
  task automatic wait_done(bit w1, int pulse, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!w1 && pulse != 0 && n == pulse) begin
        st8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end
      if (!w1 && pulse != 0 && n == pulse + 1) st8 = 1'b0;
    end while (!(w1 ? done1 : done8) && n < 20);
  endtask

  task automatic go8(logic s, logic [7:0] x, logic [7:0] y,
                     logic [7:0] es, logic ec, logic ev, int pulse);
    exp_t e;
    int n;
    e.s = es; e.c = ec; e.v = ev; e.gap = 0;
    q8.push_back(e);
    st8 = 1'b1; sb8 = s; a8 = x; b8 = y;
    @(posedge clk);
    #1 st8 = 1'b0; a8 = ~x; b8 = ~y; sb8 = ~s;
    wait_done(1'b0, pulse, n);
    chk("latency8", n, 9);
    @(posedge clk);
    #1;
  endtask

  task automatic go1(logic s, logic x, logic y, logic es, logic ec, logic ev);
    exp_t e;
    int n;
    e.s = {7'b0, es}; e.c = ec; e.v = ev; e.gap = 0;
    q1.push_back(e);
    st1 = 1'b1; sb1 = s; a1 = x; b1 = y;
    @(posedge clk);
    #1 st1 = 1'b0; a1 = ~x; b1 = ~y;
    wait_done(1'b1, 0, n);
    chk("latency1", n, 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int n;
    rst = 1'b0;
    st8 = 0; sb8 = 0; a8 = 0; b8 = 0;
    st1 = 0; sb1 = 0; a1 = 0; b1 = 0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_out8", 32'({sum8, c8, v8}), 0);
    chk("rst_out1", 32'({busy1, done1, sum1, c1, v1}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    go8(0, 8'h5A, 8'h3C, 8'h96, 0, 1, 3);
    go8(0, 8'hFF, 8'h01, 8'h00, 1, 0, 0);
    go8(1, 8'h10, 8'h20, 8'hF0, 0, 0, 0);
    go8(1, 8'h80, 8'h01, 8'h7F, 1, 1, 0);

    // Abort mid-RUN after four bits.
    st8 = 1'b1; sb8 = 0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy8", 32'(busy8), 0);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_out8", 32'({sum8, c8, v8}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    go8(0, 8'h0F, 8'h01, 8'h10, 0, 0, 0);
    go8(1, 8'h33, 8'h33, 8'h00, 1, 0, 0);

    // Start held high across two back-to-back operations.
    e.s = 8'h96; e.c = 0; e.v = 1; e.gap = 0;
    q8.push_back(e);
    st8 = 1'b1; sb8 = 0; a8 = 8'h5A; b8 = 8'h3C;
    @(posedge clk);
    #1 a8 = 8'h01; b8 = 8'h01;
    wait_done(1'b0, 0, n);
    chk("latency8_c1", n, 9);
    e.s = 8'hF0; e.c = 0; e.v = 0; e.gap = 10;
    q8.push_back(e);
    sb8 = 1; a8 = 8'h10; b8 = 8'h20;
    @(posedge clk);
    @(posedge clk);
    #1 st8 = 1'b0; sb8 = 0; a8 = 8'hAA; b8 = 8'h55;
    wait_done(1'b0, 0, n);
    chk("latency8_c2", n, 9);
    @(posedge clk);
    #1;

    go1(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    go1(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    go1(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    go1(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
